// File: rtl/tree_vote_pkg.sv
// Shared types and width helpers for the tree vote accumulator.
//   state_t : ACCUM (collecting leaf values) / HOLD (result waiting for consumer)
//   ptr_w   : pointer width for an N-entry round robin, never below 1 bit
//   sum_w   : per-sample sum width with one guard bit
//   frame_w : whole-frame total width with one guard bit
package tree_vote_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int sum_w(input int nt, input int ds);
        return $clog2(nt) + ds + 1;
    endfunction

    function automatic int frame_w(input int nt, input int ns, input int ds);
        return $clog2(nt * ns) + ds + 1;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MAX up counter used for the tree and sample pointers.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   clr   : synchronous clear (same effect as rst, lower priority only by name)
//   en    : advance by one, wrapping to 0 after MAX-1
//   count : current value; held at 0 when MAX == 1
module wrap_counter
    import tree_vote_pkg::*;
#(
    parameter int  MAX = 2,
    localparam int W   = ptr_w(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= (r_count == W'(MAX - 1)) ? '0 : r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/tree_vote_accumulator.sv
// Round-robin collector of per-tree leaf values with a per-sample threshold
// vote and a whole-frame total, presented through a valid/ready output stage.
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   flush      : synchronous abort of the current sample and frame
//   in_data    : tree t on bits [t*DATA_SIZE +: DATA_SIZE]
//   in_valid   : per-tree data valid
//   in_ready   : one-hot grant to the current tree, zero while a result is held
//   out_sum    : per-sample sum
//   out_vote   : out_sum >= THRESHOLD (unsigned)
//   out_last   : result is the final sample of its frame
//   frame_sum  : running frame total including this sample
//   out_valid  : a result is held
//   out_ready  : consumer accepts the held result
module tree_vote_accumulator
    import tree_vote_pkg::*;
#(
    parameter int  NUM_TREES   = 4,
    parameter int  NUM_SAMPLES = 2,
    parameter int  DATA_SIZE   = 4,
    parameter int  THRESHOLD   = 20,
    localparam int SUM_W       = sum_w(NUM_TREES, DATA_SIZE),
    localparam int FRAME_W     = frame_w(NUM_TREES, NUM_SAMPLES, DATA_SIZE)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [NUM_TREES*DATA_SIZE-1:0] in_data,
    input  logic [NUM_TREES-1:0]           in_valid,
    output logic [NUM_TREES-1:0]           in_ready,
    output logic [SUM_W-1:0]               out_sum,
    output logic                           out_vote,
    output logic                           out_last,
    output logic [FRAME_W-1:0]             frame_sum,
    output logic                           out_valid,
    input  logic                           out_ready
);

    localparam int TP_W = ptr_w(NUM_TREES);
    localparam int SP_W = ptr_w(NUM_SAMPLES);

    state_t               r_state;
    state_t               w_next_state;
    logic [SUM_W-1:0]     r_acc;
    logic [FRAME_W-1:0]   r_frame_acc;
    logic [SUM_W-1:0]     r_out_sum;
    logic [FRAME_W-1:0]   r_frame_sum;
    logic                 r_out_vote;
    logic                 r_out_last;
    logic                 r_out_valid;

    logic [TP_W-1:0]      w_tree_ptr;
    logic [SP_W-1:0]      w_samp_ptr;
    logic [NUM_TREES-1:0] w_grant;
    logic [DATA_SIZE-1:0] w_cur_data;
    logic [SUM_W-1:0]     w_sample_sum;
    logic                 w_in_xfer;
    logic                 w_out_xfer;
    logic                 w_last_tree;
    logic                 w_last_samp;

    // One-hot of the current tree; masking in_valid with it avoids indexing a
    // possibly 1-bit vector with a wider pointer.
    assign w_grant      = NUM_TREES'(1) << w_tree_ptr;
    assign w_in_xfer    = (r_state == ACCUM) && |(in_valid & w_grant);
    assign w_out_xfer   = r_out_valid && out_ready;
    assign w_last_tree  = (w_tree_ptr == TP_W'(NUM_TREES - 1));
    assign w_last_samp  = (w_samp_ptr == SP_W'(NUM_SAMPLES - 1));
    assign w_sample_sum = r_acc + SUM_W'(w_cur_data);

    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_cur_data = '0;
        for (int t = 0; t < NUM_TREES; t++) begin
            if (w_tree_ptr == TP_W'(t)) begin
                w_cur_data = in_data[t*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    // flush takes priority over en inside the counters, which discards an
    // input transfer coinciding with flush.
    wrap_counter #(.MAX(NUM_TREES)) u_tree_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .en    (w_in_xfer),
        .count (w_tree_ptr)
    );

    wrap_counter #(.MAX(NUM_SAMPLES)) u_samp_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .en    (w_out_xfer),
        .count (w_samp_ptr)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ACCUM: if (w_in_xfer && w_last_tree) w_next_state = HOLD;
            HOLD:  if (w_out_xfer)               w_next_state = ACCUM;
            default: w_next_state = ACCUM;
        endcase
    end

    // Output logic: grants depend on state and pointer only, never on in_valid.
    always_comb begin
        in_ready = '0;
        if (r_state == ACCUM) begin
            in_ready = w_grant;
        end
    end

    // Datapath. In-transfers only happen in ACCUM and out-transfers only in
    // HOLD, so the two branches never fire together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_frame_acc <= '0;
            r_out_sum   <= '0;
            r_frame_sum <= '0;
            r_out_vote  <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            // Result fields are left stale; they are don't-care with out_valid low.
            r_acc       <= '0;
            r_frame_acc <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_in_xfer) begin
                if (w_last_tree) begin
                    r_out_sum   <= w_sample_sum;
                    r_frame_sum <= r_frame_acc + FRAME_W'(w_sample_sum);
                    r_out_vote  <= 32'(w_sample_sum) >= $unsigned(THRESHOLD);
                    r_out_last  <= w_last_samp;
                    r_out_valid <= 1'b1;
                    r_acc       <= '0;
                end else begin
                    r_acc <= w_sample_sum;
                end
            end
            if (w_out_xfer) begin
                r_out_valid <= 1'b0;
                r_frame_acc <= r_out_last ? '0 : r_frame_sum;
            end
        end
    end

    assign out_sum   = r_out_sum;
    assign out_vote  = r_out_vote;
    assign out_last  = r_out_last;
    assign frame_sum = r_frame_sum;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_tree_vote_accumulator.sv
// Self-checking bench for tree_vote_accumulator: table-driven nominal samples,
// hand-written reset/ordering/backpressure/flush sequences, a randomized run
// against a sample-level reference model, and a 1-tree/1-sample instance.
module tb_tree_vote_accumulator;

    localparam int NT = 4;
    localparam int DS = 4;
    localparam int S  = 24;   // random-phase samples (whole frames of 2)

    logic        clk;
    logic        rst;
    logic        flush;
    logic [15:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [6:0]  out_sum;
    logic        out_vote;
    logic        out_last;
    logic [7:0]  frame_sum;
    logic        out_valid;
    logic        out_ready;

    logic [3:0]  b_in_data;
    logic [0:0]  b_in_valid;
    logic [0:0]  b_in_ready;
    logic [4:0]  b_out_sum;
    logic        b_out_vote;
    logic        b_out_last;
    logic [4:0]  b_frame_sum;
    logic        b_out_valid;
    logic        b_out_ready;

    int vectors;
    int miscompares;
    int vals[S][NT];
    int idx[NT];

    tree_vote_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_sum   (out_sum),
        .out_vote  (out_vote),
        .out_last  (out_last),
        .frame_sum (frame_sum),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    tree_vote_accumulator #(
        .NUM_TREES   (1),
        .NUM_SAMPLES (1),
        .DATA_SIZE   (4),
        .THRESHOLD   (20)
    ) dut_small (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .out_sum   (b_out_sum),
        .out_vote  (b_out_vote),
        .out_last  (b_out_last),
        .frame_sum (b_frame_sum),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;    // t3..t0 nibbles
        int          sum;
        int          vote;
        int          last;
        int          frame;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents all four values at once with every tree valid and counts edges
    // until out_valid appears.
    task automatic run_sample(input logic [15:0] data, output int lat);
        in_data  = data;
        in_valid = 4'hF;
        lat      = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        in_valid = 4'h0;
    endtask

    task automatic idle_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    // Reference: sample s is the sum of the s-th value of every tree; frames
    // are consecutive pairs of samples.
    function automatic int ref_sum(input int s);
        int acc = 0;
        for (int t = 0; t < NT; t++) acc += vals[s][t];
        return acc;
    endfunction

    function automatic int ref_frame(input int s);
        return (s % 2 == 1) ? ref_sum(s - 1) + ref_sum(s) : ref_sum(s);
    endfunction

    task automatic drive_random();
        for (int t = 0; t < NT; t++) begin
            if (idx[t] < S) begin
                in_data[t*DS +: DS] = 4'(vals[idx[t]][t]);
                in_valid[t]         = ($urandom_range(0, 9) < 7);
            end else begin
                in_data[t*DS +: DS] = 4'h0;
                in_valid[t]         = 1'b0;
            end
        end
        out_ready = ($urandom_range(0, 9) < 6);
    endtask

    initial begin
        vec_t tbl[6];
        int   lat;
        int   n_out;
        int   cyc;
        logic [3:0] xin;

        vectors     = 0;
        miscompares = 0;

        tbl[0] = '{16'h4321, 10, 0, 0, 10};
        tbl[1] = '{16'hFFFF, 60, 1, 1, 70};
        tbl[2] = '{16'h2222,  8, 0, 0,  8};
        tbl[3] = '{16'hFFFF, 60, 1, 1, 68};
        tbl[4] = '{16'hFFFF, 60, 1, 0, 60};
        tbl[5] = '{16'hFFFF, 60, 1, 1, 120};

        // ---- reset with every tree valid: nothing may be accepted ----
        rst         = 1'b1;
        flush       = 1'b0;
        in_data     = 16'hFFFF;
        in_valid    = 4'hF;
        out_ready   = 1'b1;
        b_in_data   = 4'h0;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            check("rst_in_ready", in_ready, 4'b0001);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_sum", out_sum, 0);
            check("rst_frame_sum", frame_sum, 0);
            check("rst_out_vote", out_vote, 0);
            check("rst_out_last", out_last, 0);
        end
        rst      = 1'b0;
        in_valid = 4'h0;
        step();

        // ---- nominal table: latency, sums, vote, last, frame restart, no wrap ----
        for (int i = 0; i < 6; i++) begin
            run_sample(tbl[i].data, lat);
            check("nom_latency", lat, NT);
            check("nom_out_sum", out_sum, tbl[i].sum);
            check("nom_out_vote", out_vote, tbl[i].vote);
            check("nom_out_last", out_last, tbl[i].last);
            check("nom_frame_sum", frame_sum, tbl[i].frame);
            check("nom_hold_ready", in_ready, 0);
            step();
            check("nom_released", out_valid, 0);
            check("nom_regrant", in_ready, 4'b0001);
        end

        // ---- ordering: a non-current tree is held off ----
        idle_flush();
        in_data  = 16'h6543;
        in_valid = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            step();
            check("ord_hold_off", in_ready, 4'b0001);
        end
        in_valid = 4'b0111;
        step();
        check("ord_grant_t1", in_ready, 4'b0010);
        step();
        check("ord_grant_t2", in_ready, 4'b0100);
        step();
        check("ord_grant_t3", in_ready, 4'b1000);
        check("ord_no_result", out_valid, 0);
        in_valid = 4'b1000;
        step();
        in_valid = 4'b0000;
        check("ord_out_valid", out_valid, 1);
        check("ord_out_sum", out_sum, 18);
        check("ord_out_vote", out_vote, 0);
        check("ord_out_last", out_last, 0);
        step();

        // ---- backpressure: result held stable, grants withheld ----
        idle_flush();
        out_ready = 1'b0;
        run_sample(16'hFFFF, lat);
        in_valid = 4'hF;
        for (int c = 0; c < 6; c++) begin
            step();
            check("bp_out_valid", out_valid, 1);
            check("bp_out_sum", out_sum, 60);
            check("bp_out_vote", out_vote, 1);
            check("bp_out_last", out_last, 0);
            check("bp_frame_sum", frame_sum, 60);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid  = 4'h0;
        out_ready = 1'b1;
        step();
        check("bp_released", out_valid, 0);
        check("bp_regrant", in_ready, 4'b0001);
        run_sample(16'h1111, lat);
        check("bp_next_sum", out_sum, 4);
        check("bp_next_last", out_last, 1);
        check("bp_next_frame", frame_sum, 64);
        step();

        // ---- flush mid-sample, with a coincident input offer discarded ----
        idle_flush();
        run_sample(16'h4321, lat);
        check("fl_s0_sum", out_sum, 10);
        step();
        in_data  = 16'h0077;
        in_valid = 4'b0011;
        step();
        step();
        check("fl_partial", in_ready, 4'b0100);
        in_valid = 4'b0100;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 4'b0000;
        check("fl_ptr_cleared", in_ready, 4'b0001);
        check("fl_no_valid", out_valid, 0);
        run_sample(16'h5555, lat);
        check("fl_out_sum", out_sum, 20);
        check("fl_out_vote", out_vote, 1);
        check("fl_out_last", out_last, 0);
        check("fl_frame_sum", frame_sum, 20);
        step();

        // ---- randomized run against the sample-level model ----
        idle_flush();
        for (int s = 0; s < S; s++)
            for (int t = 0; t < NT; t++)
                vals[s][t] = int'($urandom_range(0, 15));
        for (int t = 0; t < NT; t++) idx[t] = 0;
        n_out = 0;
        cyc   = 0;
        drive_random();
        while (n_out < S && cyc < 4000) begin
            @(negedge clk);
            xin = in_valid & in_ready;
            if (out_valid && out_ready) begin
                check("rnd_out_sum", out_sum, ref_sum(n_out));
                check("rnd_out_vote", out_vote, (ref_sum(n_out) >= 20) ? 1 : 0);
                check("rnd_out_last", out_last, n_out % 2);
                check("rnd_frame_sum", frame_sum, ref_frame(n_out));
                n_out++;
            end
            @(posedge clk);
            #1;
            for (int t = 0; t < NT; t++) if (xin[t]) idx[t]++;
            drive_random();
            cyc++;
        end
        check("rnd_all_samples_out", n_out, S);
        in_valid  = 4'h0;
        out_ready = 1'b1;
        step();
        step();

        // ---- single tree, single sample per frame ----
        begin
            int bv[3];
            bv = '{15, 9, 0};
            for (int i = 0; i < 3; i++) begin
                b_in_data  = 4'(bv[i]);
                b_in_valid = 1'b1;
                step();
                b_in_valid = 1'b0;
                check("one_out_valid", b_out_valid, 1);
                check("one_out_sum", b_out_sum, bv[i]);
                check("one_out_last", b_out_last, 1);
                check("one_frame_sum", b_frame_sum, bv[i]);
                check("one_hold_ready", b_in_ready, 0);
                step();
                check("one_regrant", b_in_ready, 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
